vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//   Shares one single-port synchronous board-state RAM between the pixel read path and game-logic writes.
//   Display reads win whenever the beam is in the visible area. Game-logic writes are buffered in a
//   small FIFO and drained into the RAM when the port is free.
//   With COHERENT=1, writes drain only during vertical blanking, so a displayed frame never tears.
//   Sits between the game-state logic and the pixel generation path, driven by hdata/vdata on clk_vga.
// PARAMETERS
//   WIDTH     12   width of hdata/vdata
//   HSIZE     800  visible pixels per line
//   VSIZE     600  visible lines per frame
//   ADDR_W    8    RAM address width
//   DATA_W    16   RAM data width
//   WQ_DEPTH  4    write FIFO depth, power of two, >= 2
//   COHERENT  1    1: drain only in S_VBLANK; 0: also drain in idle display cycles
// PORTS
//   clk_vga    in   1         pixel clock; the only clock
//   reset_n    in   1         asynchronous reset, active low
//   hdata      in   WIDTH     current horizontal position
//   vdata      in   WIDTH     current vertical position
//   rd_req     in   1         display requests a read this cycle
//   rd_addr    in   ADDR_W    read address
//   rd_valid   out  1         rd_data is valid (answers the grant of the previous cycle)
//   rd_data    out  DATA_W    read data
//   wr_valid   in   1         game logic offers a write
//   wr_addr    in   ADDR_W    write address
//   wr_data    in   DATA_W    write data
//   wr_ready   out  1         FIFO accepts the write (transfer = wr_valid & wr_ready)
//   ram_en     out  1         RAM port enable
//   ram_we     out  1         RAM write enable
//   ram_addr   out  ADDR_W    RAM address
//   ram_wdata  out  DATA_W    RAM write data
//   ram_rdata  in   DATA_W    RAM read data, valid one clock after an enabled read
//   vblank_o   out  1         1 while FSM is in S_VBLANK
//   wq_level   out  $clog2(WQ_DEPTH)+1  number of queued writes
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - FSM goes to S_DISPLAY; FIFO is emptied and any queued writes are discarded.
//     - rd_valid=0, rd_data=0, wr_ready=0, vblank_o=0, wq_level=0.
//     - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
//     - wr_ready is 1 from the first clock edge after release.
//   FSM:
//     - S_DISPLAY -> S_VBLANK when hdata==0 && vdata==VSIZE.
//     - S_VBLANK -> S_DISPLAY when hdata==0 && vdata==0.
//     - vblank_o is registered from the state.
//   Port grant (combinational, each cycle):
//     - Read grant: in S_DISPLAY with rd_req=1, hdata<HSIZE and vdata<VSIZE.
//       Drives ram_en=1, ram_we=0, ram_addr=rd_addr.
//     - Drain: otherwise, if the FIFO is not empty and (state==S_VBLANK or COHERENT==0).
//       Drives ram_en=1, ram_we=1, ram_addr/ram_wdata = FIFO head; the head pops at the clock edge.
//     - Else: ram_en=0, ram_we=0.
//     - rd_req outside the visible area or in S_VBLANK is ignored and gets no rd_valid.
//   Read latency:
//     - rd_valid is registered high exactly one clock after a read grant.
//     - rd_data is taken from ram_rdata in that cycle and holds its last value otherwise.
//     - Back-to-back grants give back-to-back rd_valid.
//   FIFO:
//     - wr_ready = !full, registered, so it does not depend on a pop in the same cycle.
//       A full FIFO refuses the write even if it pops that cycle.
//     - Push and pop in the same cycle leave wq_level unchanged.
//     - Read and write pointers wrap modulo WQ_DEPTH.
//     - Writes reach the RAM in acceptance order; one drain per clock at most.
//   Coherence:
//     - Reads see RAM contents only; a queued write is not forwarded to a matching read.
//     - COHERENT=1: writes accepted during a frame become visible no earlier than the next frame.
//   Reset mid-drain aborts the current RAM write: ram_en drops asynchronously.
// TESTING
//   T1 reset_n=0 mid-frame with 3 queued writes -> all outputs at reset values, wq_level=0;
//      after release wr_ready=1 and no ram_we pulse for the lost entries.
//   T2 hdata=10, vdata=5, rd_req=1, rd_addr=8'h3C, RAM[3C]=16'hBEEF
//      -> ram_en=1 & ram_we=0 same cycle; rd_valid=1, rd_data=16'hBEEF next cycle.
//   T3 COHERENT=1: push 4 writes at vdata=100 -> wr_ready=0 after the 4th, no ram_we until vdata==VSIZE;
//      then 4 consecutive ram_we cycles in push order; wq_level 4->0.
//   T4 COHERENT=0: rd_req toggles every other cycle in the visible area with 2 queued writes
//      -> writes drain only in rd_req=0 cycles and no read is ever delayed.
//   T5 FIFO full in S_VBLANK with wr_valid=1 held
//      -> push refused in the pop cycle, accepted the next cycle; wq_level goes 4,3,4...
//   T6 rd_req=1 at hdata=HSIZE or during S_VBLANK -> ram_we/ram_en follow drain only, rd_valid stays 0.

Source files
------------

// File: rtl/vram_port_arbiter_if.sv
// Bundles the game-logic write channel, the display read channel, the RAM port and the status
// outputs of vram_port_arbiter. Timing is set by the clk_vga domain of the arbiter.
// slave modport: arbiter side. master modport: the surrounding logic (game, display, RAM).
interface vram_port_arbiter_if #(
   parameter int WIDTH    = 12,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int WQ_DEPTH = 4
);
   localparam int LVL_W = $clog2(WQ_DEPTH) + 1;

   // beam position
   logic [WIDTH-1:0]  hdata;
   logic [WIDTH-1:0]  vdata;
   // display read channel
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   // game-logic write channel
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   // single-port RAM
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   // status
   logic              vblank_o;
   logic [LVL_W-1:0]  wq_level;

   modport slave (
      input  hdata, vdata, rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
      output rd_valid, rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata, vblank_o, wq_level
   );

   modport master (
      output hdata, vdata, rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
      input  rd_valid, rd_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata, vblank_o, wq_level
   );
endinterface

// File: rtl/vram_port_arbiter.sv
// Purpose : shares one single-port board-state RAM between display reads and buffered game writes.
// Latency : read data one clock after the grant; writes drain one per clock from a WQ_DEPTH FIFO.
// Backpr. : wr_ready is registered !full; display reads always win, drains wait for a free port.
// Ports   : clk_vga/reset_n plain; bus (slave modport) carries beam position, read channel,
//           write channel, RAM port, vblank_o and wq_level.
module vram_port_arbiter #(
   parameter int WIDTH    = 12,
   parameter int HSIZE    = 800,
   parameter int VSIZE    = 600,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int WQ_DEPTH = 4,
   parameter int COHERENT = 1
) (
   input  logic               clk_vga,
   input  logic               reset_n,
   vram_port_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(WQ_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {
      S_DISPLAY = 1'b0,
      S_VBLANK  = 1'b1
   } state_t;

   state_t            state_q;
   logic              vblank_q;

   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   logic              wr_ready_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_hold_q;

   logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
   logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];

   logic              visible;
   logic              rd_gnt;
   logic              drain;
   logic              push;
   logic              wq_empty;

   // ------------------------------------------------------------------
   // Port grant
   // ------------------------------------------------------------------
   assign visible  = (bus.hdata < WIDTH'(HSIZE)) && (bus.vdata < WIDTH'(VSIZE));
   assign wq_empty = (level_q == '0);
   assign rd_gnt   = (state_q == S_DISPLAY) && bus.rd_req && visible;
   assign drain    = !rd_gnt && !wq_empty && ((state_q == S_VBLANK) || (COHERENT == 0));
   assign push     = bus.wr_valid && wr_ready_q;

   // reset_n gates the RAM strobes directly so a reset in the middle of a
   // drain cycle kills the write before the next clock edge.
   assign bus.ram_en = reset_n && (rd_gnt || drain);
   assign bus.ram_we = reset_n && drain;

   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (reset_n) begin
         if (rd_gnt) begin
            bus.ram_addr = bus.rd_addr;
         end else if (drain) begin
            bus.ram_addr  = wq_addr_q[rd_ptr_q];
            bus.ram_wdata = wq_data_q[rd_ptr_q];
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM; vblank_q is loaded alongside the state so it always
   // mirrors the current state
   // ------------------------------------------------------------------
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_DISPLAY;
         vblank_q <= 1'b0;
      end else begin
         case (state_q)
            S_DISPLAY: begin
               if (bus.hdata == '0 && bus.vdata == WIDTH'(VSIZE)) begin
                  state_q  <= S_VBLANK;
                  vblank_q <= 1'b1;
               end
            end
            S_VBLANK: begin
               if (bus.hdata == '0 && bus.vdata == '0) begin
                  state_q  <= S_DISPLAY;
                  vblank_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= S_DISPLAY;
               vblank_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Write FIFO
   // ------------------------------------------------------------------
   always_comb begin
      level_d = level_q;
      if (push && !drain) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push && drain) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         wr_ready_q <= 1'b0;
      end else begin
         level_q <= level_d;
         // Computed from the next level, so wr_ready never looks at a pop
         // happening in the cycle it is offered in.
         wr_ready_q <= (level_d != LVL_W'(WQ_DEPTH));
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (drain) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Payload storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk_vga) begin
      if (push) begin
         wq_addr_q[wr_ptr_q] <= bus.wr_addr;
         wq_data_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Read return: RAM data is passed straight through in the valid cycle
   // and captured so rd_data holds its last value afterwards.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         rd_valid_q <= rd_gnt;
         if (rd_valid_q) begin
            rd_hold_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_valid_q ? bus.ram_rdata : rd_hold_q;
   assign bus.wr_ready = wr_ready_q;
   assign bus.vblank_o = vblank_q;
   assign bus.wq_level = level_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: one coherent instance (dut_c) and one
// non-coherent instance (dut_n), each with a behavioural single-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 1-2 units later.
module tb_vram_port_arbiter;
   localparam int HSIZE = 800;
   localparam int VSIZE = 600;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   vram_port_arbiter_if #(.WIDTH(12), .ADDR_W(8), .DATA_W(16), .WQ_DEPTH(4)) ifc ();
   vram_port_arbiter_if #(.WIDTH(12), .ADDR_W(8), .DATA_W(16), .WQ_DEPTH(4)) ifn ();

   vram_port_arbiter #(.WIDTH(12), .HSIZE(HSIZE), .VSIZE(VSIZE), .ADDR_W(8), .DATA_W(16),
                       .WQ_DEPTH(4), .COHERENT(1))
      dut_c (.clk_vga(clk), .reset_n(reset_n), .bus(ifc.slave));

   vram_port_arbiter #(.WIDTH(12), .HSIZE(HSIZE), .VSIZE(VSIZE), .ADDR_W(8), .DATA_W(16),
                       .WQ_DEPTH(4), .COHERENT(0))
      dut_n (.clk_vga(clk), .reset_n(reset_n), .bus(ifn.slave));

   // Behavioural RAMs plus a log of every write that reached each RAM.
   logic [15:0] mem_c [256];
   logic [15:0] mem_n [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   logic [23:0] log_c [$];
   logic [23:0] log_n [$];

   always @(posedge clk) begin
      if (pre_we) mem_c[pre_addr] <= pre_data;
      else if (ifc.ram_en && ifc.ram_we) mem_c[ifc.ram_addr] <= ifc.ram_wdata;
      if (ifc.ram_en && !ifc.ram_we) ifc.ram_rdata <= mem_c[ifc.ram_addr];
      if (ifc.ram_en && ifc.ram_we) log_c.push_back({ifc.ram_addr, ifc.ram_wdata});
   end

   always @(posedge clk) begin
      if (ifn.ram_en && ifn.ram_we) mem_n[ifn.ram_addr] <= ifn.ram_wdata;
      if (ifn.ram_en && !ifn.ram_we) ifn.ram_rdata <= mem_n[ifn.ram_addr];
      if (ifn.ram_en && ifn.ram_we) log_n.push_back({ifn.ram_addr, ifn.ram_wdata});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // T1: reset values, async abort of a drain, queued writes discarded
   task automatic test_reset();
      reset_n = 1'b0;
      ifc.hdata = 12'd10; ifc.vdata = 12'd5; ifc.rd_req = 1'b1; ifc.rd_addr = 8'h55;
      repeat (2) step();
      #1;
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b exp 0", ifc.rd_valid); end
      n_checks++; if (ifc.rd_data !== 16'h0) begin n_fail++; $display("FAIL rst_rd_data got %h exp 0000", ifc.rd_data); end
      n_checks++; if (ifc.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got %b exp 0", ifc.wr_ready); end
      n_checks++; if (ifc.vblank_o !== 1'b0) begin n_fail++; $display("FAIL rst_vblank got %b exp 0", ifc.vblank_o); end
      n_checks++; if (ifc.wq_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", ifc.wq_level); end
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en got %b exp 0", ifc.ram_en); end
      n_checks++; if (ifc.ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b exp 0", ifc.ram_we); end
      n_checks++; if (ifc.ram_addr !== 8'h0) begin n_fail++; $display("FAIL rst_ram_addr got %h exp 00", ifc.ram_addr); end
      n_checks++; if (ifc.ram_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_ram_wdata got %h exp 0000", ifc.ram_wdata); end
      ifc.rd_req = 1'b0;
      reset_n = 1'b1;
      #1;
      n_checks++; if (ifc.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rel_wr_ready_pre got %b exp 0", ifc.wr_ready); end
      step();
      n_checks++; if (ifc.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rel_wr_ready got %b exp 1", ifc.wr_ready); end
      ifc.vdata = 12'd100;
      for (int i = 0; i < 3; i++) begin
         ifc.wr_valid = 1'b1; ifc.wr_addr = 8'h40 + 8'(i); ifc.wr_data = 16'h1000 + 16'(i);
         step();
      end
      ifc.wr_valid = 1'b0;
      #1;
      n_checks++; if (ifc.wq_level !== 3'd3) begin n_fail++; $display("FAIL t1_level3 got %0d exp 3", ifc.wq_level); end
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t1_no_drain_display got %b exp 0", ifc.ram_en); end
      log_c.delete();
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.hdata = 12'd3; ifc.vdata = 12'(VSIZE + 1);
      #1;
      n_checks++; if (ifc.ram_we !== 1'b1) begin n_fail++; $display("FAIL t1_drain_start got %b exp 1", ifc.ram_we); end
      reset_n = 1'b0;
      #1;
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t1_abort_ram_en got %b exp 0", ifc.ram_en); end
      n_checks++; if (ifc.wq_level !== 3'd0) begin n_fail++; $display("FAIL t1_abort_level got %0d exp 0", ifc.wq_level); end
      n_checks++; if (ifc.vblank_o !== 1'b0) begin n_fail++; $display("FAIL t1_abort_vblank got %b exp 0", ifc.vblank_o); end
      step();
      reset_n = 1'b1;
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.hdata = 12'd3; ifc.vdata = 12'(VSIZE + 1);
      repeat (3) step();
      n_checks++; if (ifc.wr_ready !== 1'b1) begin n_fail++; $display("FAIL t1_wr_ready_after got %b exp 1", ifc.wr_ready); end
      n_checks++; if (ifc.vblank_o !== 1'b1) begin n_fail++; $display("FAIL t1_vblank_after got %b exp 1", ifc.vblank_o); end
      n_checks++; if (log_c.size() !== 0) begin n_fail++; $display("FAIL t1_lost_writes got %0d exp 0", log_c.size()); end
      ifc.hdata = 12'd0; ifc.vdata = 12'd0;
      step();
   endtask

   // T2: single read latency plus a back-to-back pair
   task automatic test_read();
      pre_we = 1'b1; pre_addr = 8'h3C; pre_data = 16'hBEEF;
      step();
      pre_addr = 8'h3D; pre_data = 16'h1234;
      step();
      pre_we = 1'b0;
      ifc.hdata = 12'd10; ifc.vdata = 12'd5; ifc.rd_req = 1'b1; ifc.rd_addr = 8'h3C;
      #1;
      n_checks++; if (ifc.ram_en !== 1'b1) begin n_fail++; $display("FAIL t2_ram_en got %b exp 1", ifc.ram_en); end
      n_checks++; if (ifc.ram_we !== 1'b0) begin n_fail++; $display("FAIL t2_ram_we got %b exp 0", ifc.ram_we); end
      n_checks++; if (ifc.ram_addr !== 8'h3C) begin n_fail++; $display("FAIL t2_ram_addr got %h exp 3c", ifc.ram_addr); end
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t2_rd_valid_early got %b exp 0", ifc.rd_valid); end
      step();
      ifc.rd_addr = 8'h3D;
      #1;
      n_checks++; if (ifc.rd_valid !== 1'b1) begin n_fail++; $display("FAIL t2_rd_valid got %b exp 1", ifc.rd_valid); end
      n_checks++; if (ifc.rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL t2_rd_data got %h exp beef", ifc.rd_data); end
      step();
      ifc.rd_req = 1'b0;
      #1;
      n_checks++; if (ifc.rd_valid !== 1'b1) begin n_fail++; $display("FAIL t2_b2b_valid got %b exp 1", ifc.rd_valid); end
      n_checks++; if (ifc.rd_data !== 16'h1234) begin n_fail++; $display("FAIL t2_b2b_data got %h exp 1234", ifc.rd_data); end
      step();
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t2_valid_drop got %b exp 0", ifc.rd_valid); end
      n_checks++; if (ifc.rd_data !== 16'h1234) begin n_fail++; $display("FAIL t2_data_hold got %h exp 1234", ifc.rd_data); end
   endtask

   // T3: coherent mode holds writes until vblank, then drains in order
   task automatic test_coherent();
      logic [11:0] vs [3];
      logic [11:0] hs [3];
      log_c.delete();
      ifc.hdata = 12'd10; ifc.vdata = 12'd100; ifc.rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ifc.wr_valid = 1'b1; ifc.wr_addr = 8'h10 + 8'(i); ifc.wr_data = 16'hA000 + 16'(i);
         step();
      end
      ifc.wr_valid = 1'b0;
      #1;
      n_checks++; if (ifc.wr_ready !== 1'b0) begin n_fail++; $display("FAIL t3_full_ready got %b exp 0", ifc.wr_ready); end
      n_checks++; if (ifc.wq_level !== 3'd4) begin n_fail++; $display("FAIL t3_level4 got %0d exp 4", ifc.wq_level); end
      // near-miss positions: none of them may start vblank
      vs[0] = 12'd200; hs[0] = 12'd0;
      vs[1] = 12'd599; hs[1] = 12'd0;
      vs[2] = 12'(VSIZE); hs[2] = 12'd5;
      for (int i = 0; i < 3; i++) begin
         ifc.vdata = vs[i]; ifc.hdata = hs[i];
         step();
      end
      n_checks++; if (log_c.size() !== 0) begin n_fail++; $display("FAIL t3_early_drain got %0d exp 0", log_c.size()); end
      n_checks++; if (ifc.vblank_o !== 1'b0) begin n_fail++; $display("FAIL t3_early_vblank got %b exp 0", ifc.vblank_o); end
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.hdata = 12'd1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (ifc.wq_level !== 3'(4 - k)) begin n_fail++; $display("FAIL t3_level got %0d exp %0d", ifc.wq_level, 4 - k); end
         n_checks++; if (ifc.ram_we !== 1'b1 || ifc.ram_addr !== 8'h10 + 8'(k)) begin n_fail++; $display("FAIL t3_drain got we=%b addr=%h exp we=1 addr=%h", ifc.ram_we, ifc.ram_addr, 8'h10 + 8'(k)); end
         step();
      end
      n_checks++; if (ifc.wq_level !== 3'd0) begin n_fail++; $display("FAIL t3_level0 got %0d exp 0", ifc.wq_level); end
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t3_idle got %b exp 0", ifc.ram_en); end
      n_checks++; if (log_c.size() !== 4) begin n_fail++; $display("FAIL t3_log_size got %0d exp 4", log_c.size()); end
      if (log_c.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            n_checks++; if (log_c[k] !== {8'h10 + 8'(k), 16'hA000 + 16'(k)}) begin n_fail++; $display("FAIL t3_order got %h exp %h", log_c[k], {8'h10 + 8'(k), 16'hA000 + 16'(k)}); end
         end
      end
      ifc.hdata = 12'd0; ifc.vdata = 12'd0;
      step();
      ifc.hdata = 12'd10; ifc.vdata = 12'd5; ifc.rd_req = 1'b1; ifc.rd_addr = 8'h12;
      step();
      ifc.rd_req = 1'b0;
      n_checks++; if (ifc.rd_valid !== 1'b1 || ifc.rd_data !== 16'hA002) begin n_fail++; $display("FAIL t3_next_frame got v=%b d=%h exp v=1 d=a002", ifc.rd_valid, ifc.rd_data); end
   endtask

   // T5: full FIFO refuses the offered write in the pop cycle, takes it next cycle
   task automatic test_full_pop();
      log_c.delete();
      ifc.hdata = 12'd10; ifc.vdata = 12'd100; ifc.rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ifc.wr_valid = 1'b1; ifc.wr_addr = 8'h20 + 8'(i); ifc.wr_data = 16'hB000 + 16'(i);
         step();
      end
      ifc.wr_addr = 8'h2F; ifc.wr_data = 16'hCAFE;
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.vdata = 12'd0;
      #1;
      n_checks++; if (ifc.wq_level !== 3'd4 || ifc.wr_ready !== 1'b0) begin n_fail++; $display("FAIL t5_full got lvl=%0d rdy=%b exp lvl=4 rdy=0", ifc.wq_level, ifc.wr_ready); end
      n_checks++; if (ifc.ram_we !== 1'b1 || ifc.ram_addr !== 8'h20) begin n_fail++; $display("FAIL t5_pop got we=%b addr=%h exp we=1 addr=20", ifc.ram_we, ifc.ram_addr); end
      step();
      n_checks++; if (ifc.wq_level !== 3'd3 || ifc.wr_ready !== 1'b1) begin n_fail++; $display("FAIL t5_after_pop got lvl=%0d rdy=%b exp lvl=3 rdy=1", ifc.wq_level, ifc.wr_ready); end
      n_checks++; if (ifc.vblank_o !== 1'b0 || ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t5_display got vb=%b en=%b exp vb=0 en=0", ifc.vblank_o, ifc.ram_en); end
      step();
      ifc.wr_valid = 1'b0;
      n_checks++; if (ifc.wq_level !== 3'd4 || ifc.wr_ready !== 1'b0) begin n_fail++; $display("FAIL t5_refill got lvl=%0d rdy=%b exp lvl=4 rdy=0", ifc.wq_level, ifc.wr_ready); end
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.hdata = 12'd1;
      repeat (4) step();
      n_checks++; if (ifc.wq_level !== 3'd0) begin n_fail++; $display("FAIL t5_drained got %0d exp 0", ifc.wq_level); end
      n_checks++; if (log_c.size() !== 5) begin n_fail++; $display("FAIL t5_log_size got %0d exp 5", log_c.size()); end
      if (log_c.size() == 5) begin
         n_checks++; if (log_c[0] !== 24'h20B000) begin n_fail++; $display("FAIL t5_first got %h exp 20b000", log_c[0]); end
         n_checks++; if (log_c[4] !== 24'h2FCAFE) begin n_fail++; $display("FAIL t5_last got %h exp 2fcafe", log_c[4]); end
      end
      ifc.hdata = 12'd0; ifc.vdata = 12'd0;
      step();
   endtask

   // T4: non-coherent drains only in idle display cycles, reads never delayed
   task automatic test_no_delay();
      logic prev_req;
      logic cur_req;
      log_n.delete();
      ifn.hdata = 12'd10; ifn.vdata = 12'd50; ifn.rd_req = 1'b1; ifn.rd_addr = 8'h01;
      for (int i = 0; i < 2; i++) begin
         ifn.wr_valid = 1'b1; ifn.wr_addr = 8'h30 + 8'(i); ifn.wr_data = 16'hC000 + 16'(i);
         step();
      end
      ifn.wr_valid = 1'b0;
      n_checks++; if (ifn.wq_level !== 3'd2) begin n_fail++; $display("FAIL t4_level2 got %0d exp 2", ifn.wq_level); end
      prev_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cur_req = (k % 2 == 0);
         ifn.rd_req = cur_req;
         ifn.rd_addr = (k == 4) ? 8'h31 : 8'h60 + 8'(k);
         #1;
         n_checks++; if (ifn.rd_valid !== prev_req) begin n_fail++; $display("FAIL t4_rd_valid got %b exp %b", ifn.rd_valid, prev_req); end
         n_checks++; if (ifn.ram_en !== (k != 5)) begin n_fail++; $display("FAIL t4_ram_en got %b exp %b", ifn.ram_en, k != 5); end
         n_checks++; if (ifn.ram_we !== (k == 1 || k == 3)) begin n_fail++; $display("FAIL t4_ram_we got %b exp %b", ifn.ram_we, k == 1 || k == 3); end
         if (cur_req) begin
            n_checks++; if (ifn.ram_addr !== ifn.rd_addr) begin n_fail++; $display("FAIL t4_rd_addr got %h exp %h", ifn.ram_addr, ifn.rd_addr); end
         end
         prev_req = cur_req;
         step();
      end
      n_checks++; if (ifn.rd_data !== 16'hC001) begin n_fail++; $display("FAIL t4_rd_after_drain got %h exp c001", ifn.rd_data); end
      n_checks++; if (ifn.wq_level !== 3'd0) begin n_fail++; $display("FAIL t4_level0 got %0d exp 0", ifn.wq_level); end
      n_checks++; if (log_n.size() !== 2) begin n_fail++; $display("FAIL t4_log_size got %0d exp 2", log_n.size()); end
      if (log_n.size() == 2) begin
         n_checks++; if (log_n[0] !== 24'h30C000 || log_n[1] !== 24'h31C001) begin n_fail++; $display("FAIL t4_order got %h %h exp 30c000 31c001", log_n[0], log_n[1]); end
      end
   endtask

   // T6: reads outside the visible area or in vblank are ignored
   task automatic test_ignored_read();
      ifc.rd_req = 1'b1; ifc.rd_addr = 8'h3C; ifc.hdata = 12'(HSIZE); ifc.vdata = 12'd5;
      #1;
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t6_hsize_en got %b exp 0", ifc.ram_en); end
      step();
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_hsize_valid got %b exp 0", ifc.rd_valid); end
      ifc.hdata = 12'd10; ifc.vdata = 12'(VSIZE + 2);
      #1;
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t6_vsize_en got %b exp 0", ifc.ram_en); end
      ifc.hdata = 12'(HSIZE - 1); ifc.vdata = 12'(VSIZE - 1);
      #1;
      n_checks++; if (ifc.ram_en !== 1'b1 || ifc.ram_we !== 1'b0) begin n_fail++; $display("FAIL t6_corner got en=%b we=%b exp en=1 we=0", ifc.ram_en, ifc.ram_we); end
      step();
      ifc.rd_req = 1'b0;
      ifc.wr_valid = 1'b1; ifc.wr_addr = 8'h50; ifc.wr_data = 16'hD00D; ifc.hdata = 12'd10;
      step();
      ifc.wr_valid = 1'b0; ifc.rd_req = 1'b1;
      ifc.hdata = 12'd0; ifc.vdata = 12'(VSIZE);
      step();
      ifc.hdata = 12'd5; ifc.vdata = 12'd3;
      #1;
      n_checks++; if (ifc.ram_we !== 1'b1 || ifc.ram_addr !== 8'h50) begin n_fail++; $display("FAIL t6_vb_drain got we=%b addr=%h exp we=1 addr=50", ifc.ram_we, ifc.ram_addr); end
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_vb_valid0 got %b exp 0", ifc.rd_valid); end
      step();
      n_checks++; if (ifc.ram_en !== 1'b0) begin n_fail++; $display("FAIL t6_vb_read_en got %b exp 0", ifc.ram_en); end
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_vb_valid1 got %b exp 0", ifc.rd_valid); end
      step();
      n_checks++; if (ifc.rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_vb_valid2 got %b exp 0", ifc.rd_valid); end
      ifc.rd_req = 1'b0; ifc.hdata = 12'd0; ifc.vdata = 12'd0;
      step();
   endtask

   initial begin
      ifc.hdata = '0; ifc.vdata = '0; ifc.rd_req = 1'b0; ifc.rd_addr = '0;
      ifc.wr_valid = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
      ifn.hdata = '0; ifn.vdata = '0; ifn.rd_req = 1'b0; ifn.rd_addr = '0;
      ifn.wr_valid = 1'b0; ifn.wr_addr = '0; ifn.wr_data = '0;
      test_reset();
      test_read();
      test_coherent();
      test_full_pop();
      test_no_delay();
      test_ignored_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
